// File: rtl/cpu_pkg.sv
// Shared CPU definitions: program-counter width and type, default return-stack depth,
// and the per-cycle PC action decode used by pc_ctrl.
//
// Contents:
//   PC_W            program-counter width (16)
//   pc_t            program-counter word type
//   STACK_DEPTH_DEF default return-stack depth
//   pc_op_e         the single PC action that takes effect in a cycle
//   decode_op()     fixed-priority decode: halt > ret > call > jmp_load > pc_inc > hold
package cpu_pkg;

  localparam int unsigned PC_W            = 16;
  localparam int unsigned STACK_DEPTH_DEF = 4;

  typedef logic [PC_W-1:0] pc_t;

  typedef enum logic [2:0] {
    OpHold,
    OpInc,
    OpJmp,
    OpCall,
    OpRet,
    OpHalt
  } pc_op_e;

  function automatic pc_op_e decode_op(input logic halt, input logic ret, input logic call,
                                       input logic jmp_load, input logic pc_inc);
    pc_op_e op;
    if (halt) begin
      op = OpHalt;
    end else if (ret) begin
      op = OpRet;
    end else if (call) begin
      op = OpCall;
    end else if (jmp_load) begin
      op = OpJmp;
    end else if (pc_inc) begin
      op = OpInc;
    end else begin
      op = OpHold;
    end
    return op;
  endfunction

endpackage

// File: rtl/pc_stack.sv
// Return-address LIFO for pc_ctrl: storage, occupancy count and flags.
//
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset (clears count and err only)
//   push        store push_data on top (dropped with err set when full)
//   pop         discard the top entry (err set when empty)
//   push_data   return address to store
//   top         most recently pushed entry (meaningless while empty)
//   empty/full  derived combinationally from the registered count
//   err         sticky overflow/underflow flag, cleared only by reset
// push and pop are never asserted together by pc_ctrl; push wins if they are.
module pc_stack
  import cpu_pkg::*;
#(
  parameter int unsigned STACK_DEPTH = STACK_DEPTH_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  logic pop,
  input  pc_t  push_data,
  output pc_t  top,
  output logic empty,
  output logic full,
  output logic err
);

  localparam int unsigned AW = $clog2(STACK_DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [CW-1:0] count_q, count_d;
  logic          err_q, err_d;
  logic [AW-1:0] wr_idx, rd_idx;
  pc_t           mem_q [STACK_DEPTH];

  assign empty  = (count_q == '0);
  assign full   = (count_q == CW'(STACK_DEPTH));
  assign err    = err_q;

  // Power-of-two depth: the low count bits address the next free slot, and
  // the slot below it is the top.
  assign wr_idx = count_q[AW-1:0];
  assign rd_idx = wr_idx - AW'(1);
  assign top    = mem_q[rd_idx];

  always_comb begin
    count_d = count_q;
    err_d   = err_q;
    if (push) begin
      if (full) begin
        err_d = 1'b1;
      end else begin
        count_d = count_q + CW'(1);
      end
    end else if (pop) begin
      if (empty) begin
        err_d = 1'b1;
      end else begin
        count_d = count_q - CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  // Entry contents are not reset; they are unobservable until written.
  always_ff @(posedge clk) begin
    if (push && !full) begin
      mem_q[wr_idx] <= push_data;
    end
  end

endmodule

// File: rtl/pc_ctrl.sv
// Program-counter controller with optional return-address stack.
//
// Build option: define PC_CTRL_STACK_EN to include the return stack (pc_stack).
// Without it, call behaves as jmp_load, ret does nothing but still outranks
// lower-priority actions, and the stack flags are tied off.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   pc_inc       advance pc by one (wraps at 0xFFFF)
//   jmp_load     load jmp_addr into pc on the next edge
//   jmp_addr     jump / call target
//   call         push current pc, load jmp_addr
//   ret          pop return address into pc
//   halt         freeze pc and stack
//   pc           registered program counter
//   stack_empty  no return addresses held
//   stack_full   STACK_DEPTH return addresses held
//   stack_err    sticky overflow/underflow flag
// Only the highest-priority asserted action takes effect:
// halt > ret > call > jmp_load > pc_inc > hold.
module pc_ctrl
  import cpu_pkg::*;
#(
  parameter int unsigned STACK_DEPTH = STACK_DEPTH_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pc_inc,
  input  logic jmp_load,
  input  pc_t  jmp_addr,
  input  logic call,
  input  logic ret,
  input  logic halt,
  output pc_t  pc,
  output logic stack_empty,
  output logic stack_full,
  output logic stack_err
);

  if (STACK_DEPTH < 2 || STACK_DEPTH > 16 || (STACK_DEPTH & (STACK_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("pc_ctrl: STACK_DEPTH must be a power of two in 2..16");
  end

  pc_op_e op_raw, op;
  pc_t    pc_q, pc_d;
  pc_t    ret_pc;

  assign op_raw = decode_op(halt, ret, call, jmp_load, pc_inc);

`ifdef PC_CTRL_STACK_EN
  pc_t stack_top;

  assign op = op_raw;

  pc_stack #(
    .STACK_DEPTH(STACK_DEPTH)
  ) u_pc_stack (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (op == OpCall),
    .pop      (op == OpRet),
    .push_data(pc_q),
    .top      (stack_top),
    .empty    (stack_empty),
    .full     (stack_full),
    .err      (stack_err)
  );

  // Underflowing ret holds pc; the stack records the error.
  assign ret_pc = stack_empty ? pc_q : stack_top;
`else
  assign op          = (op_raw == OpCall) ? OpJmp : op_raw;
  assign ret_pc      = pc_q;
  assign stack_empty = 1'b1;
  assign stack_full  = 1'b0;
  assign stack_err   = 1'b0;
`endif

  always_comb begin
    pc_d = pc_q;
    case (op)
      OpInc:          pc_d = pc_q + pc_t'(1);
      OpJmp, OpCall:  pc_d = jmp_addr;
      OpRet:          pc_d = ret_pc;
      default:        pc_d = pc_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= '0;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc = pc_q;

endmodule

// File: doc/pc_ctrl.md
PC_CTRL -- requirements
Module: pc_ctrl

Interface
REQ-001 SHALL have parameter STACK_DEPTH, default 4, meaning the number of return-address entries (power of two, 2..16).
REQ-002 SHALL have port clk  input  1  system clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port pc_inc  input  1  advance PC by one this cycle.
REQ-005 SHALL have port jmp_load  input  1  load jmp_addr into PC; driven by the jump unit's pcoe.
REQ-006 SHALL have port jmp_addr  input  16  jump target; driven by the jump unit's pcout.
REQ-007 SHALL have port call  input  1  push the return address and load jmp_addr.
REQ-008 SHALL have port ret  input  1  pop the return address into PC.
REQ-009 SHALL have port halt  input  1  freeze PC and stack.
REQ-010 SHALL have port pc  output  16  current program counter; also feeds the jump unit's pcin.
REQ-011 SHALL have port stack_empty  output  1  no entries held.
REQ-012 SHALL have port stack_full  output  1  STACK_DEPTH entries held.
REQ-013 SHALL have port stack_err  output  1  sticky overflow/underflow flag.

Function
REQ-014 SHALL apply per-cycle priority: halt > ret > call > jmp_load > pc_inc > hold; only the highest asserted action takes effect.
REQ-015 SHALL, on pc_inc, set pc <= pc + 1 modulo 2^16 (0xFFFF wraps to 0x0000, with no flag).
REQ-016 SHALL, on jmp_load, set pc <= jmp_addr on the next edge (one-cycle latency, no combinational path from jmp_addr to pc).
REQ-017 SHALL, on call when not full, write the current pc to the stack top, increment the stack count, and set pc <= jmp_addr.
REQ-018 SHALL, on call when full, drop the push, keep existing entries, still set pc <= jmp_addr, and set stack_err.
REQ-019 SHALL, on ret when not empty, set pc <= top entry and decrement the count.
REQ-020 SHALL, on ret when empty, hold pc and set stack_err.
REQ-021 SHALL clear stack_err only by reset.
REQ-022 SHALL derive stack_empty and stack_full combinationally from the registered count (count 0..STACK_DEPTH, width clog2(STACK_DEPTH)+1).
REQ-023 SHALL, while halt is high, ignore every other input and change no state.

Reset
REQ-024 SHALL, while rst_n is low, force pc=0x0000, count=0, stack_empty=1, stack_full=0, stack_err=0, independent of clk.
REQ-025 SHALL leave stack entry contents undefined after reset; they are never observable while empty.
REQ-026 SHALL abandon any in-flight call or ret on reset mid-cycle, with no partial update surviving.

Configuration
REQ-027 SHALL, with macro PC_CTRL_STACK_EN defined, implement the return stack as specified above.
REQ-028 SHALL, without PC_CTRL_STACK_EN, treat call as jmp_load, treat ret as no-op, tie stack_empty=1, stack_full=0, stack_err=0, and infer no stack storage.

Structure
REQ-029 SHALL place PC_W=16, typedef pc_t (logic [15:0]), and default STACK_DEPTH in shared package cpu_pkg.
REQ-030 SHALL implement the LIFO storage, count, and flags in one sub-module, pc_stack, instantiated only under PC_CTRL_STACK_EN.

Verification
REQ-031 SHALL cover reset then 3 cycles of pc_inc -> pc=0x0003; pc=0xFFFF with pc_inc -> pc=0x0000.
REQ-032 SHALL cover pc=0x0010, jmp_load with jmp_addr=0x1234 and pc_inc together -> pc=0x1234 next cycle, not 0x0011.
REQ-033 SHALL cover pc=0x0020, call to 0x0100, then ret -> pc=0x0100, then 0x0020, with stack_empty=1 afterwards.
REQ-034 SHALL cover 5 nested calls with STACK_DEPTH=4 -> stack_full=1 and stack_err=1 after the 5th, pc=5th target, and 4 rets return the first 4 addresses in LIFO order.
REQ-035 SHALL cover ret on empty stack at pc=0x0042 -> pc stays 0x0042 and stack_err=1; halt held with call asserted -> pc and count unchanged.
REQ-036 SHALL cover rst_n low mid-call -> pc=0x0000 and count=0 immediately, without waiting for a clock edge.
